// File: rtl/uc_multiciclo_pkg.sv
// rtl/uc_multiciclo_pkg.sv - shared encodings for the multicycle MIPS-subset control unit
//
// Purpose: the FSM state encoding, opcode constants and the datapath
//          selector codes (ALUOP, ALUSrcB, PCSrc). The control unit and
//          ALUControl both import these.
// Ports:   none (package)
package uc_multiciclo_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_WB_MEM   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ERROR    = 4'd9
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    // ALUOP codes handed to ALUControl
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B selector
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source selector
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // States that hold a memory request open and are therefore guarded by the timeout
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/uc_mem_timeout.sv
// rtl/uc_mem_timeout.sv - wait-cycle counter guarding a memory request
//
// Purpose: counts consecutive cycles a memory request has been waiting
//          without ready. The count restarts whenever the request is not
//          waiting (completed, or the FSM is outside a memory state), so
//          every entry into a memory state starts from zero.
//          expire fires on the last allowed cycle (count TIMEOUT-1) only if
//          ready is still low, so ready on that cycle wins.
// Ports:
//   clk     in   1  clock
//   rst_n   in   1  asynchronous active-low reset
//   waiting in   1  FSM is in a memory state with a request outstanding
//   ready   in   1  memory ready (Listo)
//   expire  out  1  request has exhausted its TIMEOUT cycles
module uc_mem_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic ready,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (waiting && !ready) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign expire = waiting && !ready && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle control FSM for the MIPS-subset datapath
//
// Purpose: sequences R-type, lw, sw and beq over 3-5 cycles (plus memory
//          wait states), drives every datapath strobe, guards each memory
//          access with a timeout and counts retired instructions.
// Ports:
//   CLK          in   1      clock
//   RST_n        in   1      asynchronous active-low reset
//   OP           in   6      opcode, sampled in DECODE only
//   ZF           in   1      ALU zero flag (gating is done by the datapath)
//   Listo        in   1      memory ready; access completes in that cycle
//   PCWrite      out  1      unconditional PC load
//   PCWriteCond  out  1      PC load if ZF
//   IorD         out  1      memory address select (0=PC, 1=ALUOut)
//   MemLeer      out  1      memory read request
//   MemESC       out  1      memory write request
//   IRWrite      out  1      instruction register load
//   MemToReg     out  1      register write data select (0=ALUOut, 1=MDR)
//   RegDst       out  1      register write address select (0=rt, 1=rd)
//   RegToWrite   out  1      register file write enable
//   ALUSrcA      out  1      ALU operand A select (0=PC, 1=DR1)
//   ALUSrcB      out  2      ALU operand B select
//   ALUOP        out  2      ALU operation class
//   PCSrc        out  2      PC source select
//   Error        out  1      sticky illegal-opcode / memory-timeout flag
//   Retired      out  CNT_W  instructions completed since reset (wraps)
module uc_multiciclo #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [5:0]       OP,
    input  logic             ZF,
    input  logic             Listo,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemLeer,
    output logic             MemESC,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegToWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOP,
    output logic [1:0]       PCSrc,
    output logic             Error,
    output logic [CNT_W-1:0] Retired
);

    import uc_multiciclo_pkg::*;

    state_t           state;
    state_t           state_next;
    logic             is_sw;
    logic             waiting;
    logic             expire;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // The branch condition is applied in the datapath (PCWriteCond & ZF);
    // the controller raises PCWriteCond for every beq regardless of ZF.
    logic unused_zf;
    assign unused_zf = ZF;

    assign waiting = is_mem_state(state);

    uc_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (RST_n),
        .waiting (waiting),
        .ready   (Listo),
        .expire  (expire)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // OP is only valid in DECODE, so the lw/sw split needed one cycle later
    // in MEM_ADDR is remembered here.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            is_sw <= 1'b0;
        end else if (state == ST_DECODE) begin
            is_sw <= (OP == OP_SW);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign Retired = retired_q;

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            ST_FETCH: begin
                if (Listo) begin
                    state_next = ST_DECODE;
                end else if (expire) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                case (OP)
                    OP_R:         state_next = ST_EXEC_R;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    default:      state_next = ST_ERROR;
                endcase
            end
            ST_EXEC_R: begin
                state_next = ST_WB_R;
            end
            ST_WB_R: begin
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                state_next = is_sw ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (Listo) begin
                    state_next = ST_WB_MEM;
                end else if (expire) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WB_MEM: begin
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (Listo) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (expire) begin
                    state_next = ST_ERROR;
                end
            end
            ST_BRANCH: begin
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase
    end

    // Moore decode from state. While RST_n is low every strobe is forced to
    // zero so an abandoned request is withdrawn in the same cycle, even
    // though the reset state (FETCH) would otherwise assert MemLeer.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemLeer     = 1'b0;
        MemESC      = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegToWrite  = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOP       = ALUOP_ADD;
        PCSrc       = PCSRC_ALU;
        Error       = 1'b0;
        if (RST_n) begin
            case (state)
                ST_FETCH: begin
                    MemLeer = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    // PC+4 and IR are only captured in the cycle the fetch completes
                    IRWrite = Listo;
                    PCWrite = Listo;
                end
                ST_DECODE: begin
                    // Precompute the branch target into ALUOut
                    ALUSrcB = SRCB_IMM_SH2;
                end
                ST_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOP   = ALUOP_FUNCT;
                end
                ST_WB_R: begin
                    RegDst     = 1'b1;
                    RegToWrite = 1'b1;
                end
                ST_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    IorD    = 1'b1;
                    MemLeer = 1'b1;
                end
                ST_WB_MEM: begin
                    MemToReg   = 1'b1;
                    RegToWrite = 1'b1;
                end
                ST_MEM_WR: begin
                    IorD   = 1'b1;
                    MemESC = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOP       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSrc       = PCSRC_ALUOUT;
                end
                ST_ERROR: begin
                    Error = 1'b1;
                end
                default: begin
                    Error = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - self-checking bench for uc_multiciclo
module tb_uc_multiciclo;

    localparam int TO = 16;
    localparam int CW = 4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [5:0]    OP = 6'd0;
    logic          ZF = 1'b0;
    logic          Listo = 1'b0;
    logic          PCWrite, PCWriteCond, IorD, MemLeer, MemESC, IRWrite;
    logic          MemToReg, RegDst, RegToWrite, ALUSrcA, Error;
    logic [1:0]    ALUSrcB, ALUOP, PCSrc;
    logic [CW-1:0] Retired;

    uc_multiciclo #(
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .OP          (OP),
        .ZF          (ZF),
        .Listo       (Listo),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemLeer     (MemLeer),
        .MemESC      (MemESC),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegToWrite  (RegToWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOP       (ALUOP),
        .PCSrc       (PCSrc),
        .Error       (Error),
        .Retired     (Retired)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          pcw;
        logic          pcwc;
        logic          iord;
        logic          mrd;
        logic          mwr;
        logic          irw;
        logic          m2r;
        logic          rdst;
        logic          rw;
        logic          srca;
        logic [1:0]    srcb;
        logic [1:0]    aluop;
        logic [1:0]    pcsrc;
        logic          err;
        logic [CW-1:0] ret;
    } ctl_t;

    ctl_t  act;
    ctl_t  exp_c;
    logic  exp_valid = 1'b0;
    string step_name = "";
    int    checks = 0;
    int    errors = 0;
    int    model_ret = 0;
    logic  model_err = 1'b0;
    int    cycles = 0;

    assign act = {PCWrite, PCWriteCond, IorD, MemLeer, MemESC, IRWrite, MemToReg,
                  RegDst, RegToWrite, ALUSrcA, ALUSrcB, ALUOP, PCSrc, Error, Retired};

    // Single compare point, half a cycle after inputs settle
    always @(negedge CLK) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_c) begin
                errors++;
                $display("FAIL %s @%0t: actual %h required %h", step_name, $time, act, exp_c);
            end
        end
    end

    task automatic check(input string nm, input int a, input int r);
        checks++;
        if (a != r) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, a, r);
        end
    endtask

    // Expected outputs of a cycle with no strobes: only Error and Retired visible
    function automatic ctl_t idle();
        ctl_t c;
        c     = '0;
        c.err = model_err;
        c.ret = CW'(model_ret % (1 << CW));
        return c;
    endfunction

    task automatic cyc(input logic rst, input logic listo, input logic [5:0] op,
                       input logic zf, input ctl_t e, input string nm);
        @(posedge CLK);
        #1;
        RST_n     = rst;
        Listo     = listo;
        OP        = op;
        ZF        = zf;
        exp_c     = e;
        step_name = nm;
        exp_valid = 1'b1;
        cycles++;
    endtask

    task automatic do_reset();
        model_ret = 0;
        model_err = 1'b0;
        cyc(1'b0, 1'b1, OP_LW, 1'b1, idle(), "reset");
    endtask

    // Fetch with `waits` cycles of Listo=0; TO or more waits ends in ERROR
    task automatic do_fetch(input int waits, input logic [5:0] noise, output logic timed_out);
        ctl_t e;
        int   n;
        timed_out = 1'b0;
        n = (waits < TO) ? waits : TO;
        for (int i = 0; i < n; i++) begin
            e = idle(); e.mrd = 1'b1; e.srcb = 2'b01;
            cyc(1'b1, 1'b0, noise, 1'b0, e, "fetch_wait");
        end
        if (waits >= TO) begin
            model_err = 1'b1;
            timed_out = 1'b1;
            return;
        end
        e = idle(); e.mrd = 1'b1; e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(1'b1, 1'b1, noise, 1'b0, e, "fetch_done");
    endtask

    task automatic do_decode(input logic [5:0] op);
        ctl_t e;
        e = idle(); e.srcb = 2'b11;
        cyc(1'b1, 1'b1, op, 1'b1, e, "decode");
        if (op != OP_R && op != OP_LW && op != OP_SW && op != OP_BEQ)
            model_err = 1'b1;
    endtask

    task automatic do_mem_addr(input logic [5:0] noise);
        ctl_t e;
        e = idle(); e.srca = 1'b1; e.srcb = 2'b10;
        cyc(1'b1, 1'b1, noise, 1'b0, e, "mem_addr");
    endtask

    task automatic do_mem(input logic wr, input int waits, input logic [5:0] noise,
                          output logic timed_out);
        ctl_t e;
        int   n;
        timed_out = 1'b0;
        n = (waits < TO) ? waits : TO;
        e = idle(); e.iord = 1'b1; e.mrd = !wr; e.mwr = wr;
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, noise, 1'b0, e, wr ? "mem_wr_wait" : "mem_rd_wait");
        if (waits >= TO) begin
            model_err = 1'b1;
            timed_out = 1'b1;
            return;
        end
        cyc(1'b1, 1'b1, noise, 1'b0, e, wr ? "mem_wr_done" : "mem_rd_done");
    endtask

    task automatic instr_r(input int fw);
        ctl_t e;
        logic to;
        cycles = 0;
        do_fetch(fw, OP_LW, to);
        if (to) return;
        do_decode(OP_R);
        e = idle(); e.srca = 1'b1; e.aluop = 2'b10;
        cyc(1'b1, 1'b1, OP_LW, 1'b0, e, "exec_r");
        e = idle(); e.rdst = 1'b1; e.rw = 1'b1;
        cyc(1'b1, 1'b1, OP_LW, 1'b0, e, "wb_r");
        model_ret++;
    endtask

    task automatic instr_lw(input int fw, input int mw);
        ctl_t e;
        logic to;
        cycles = 0;
        do_fetch(fw, OP_SW, to);
        if (to) return;
        do_decode(OP_LW);
        do_mem_addr(OP_SW);
        do_mem(1'b0, mw, OP_SW, to);
        if (to) return;
        e = idle(); e.m2r = 1'b1; e.rw = 1'b1;
        cyc(1'b1, 1'b1, OP_SW, 1'b0, e, "wb_mem");
        model_ret++;
    endtask

    task automatic instr_sw(input int fw, input int mw);
        logic to;
        cycles = 0;
        do_fetch(fw, OP_LW, to);
        if (to) return;
        do_decode(OP_SW);
        do_mem_addr(OP_LW);
        do_mem(1'b1, mw, OP_LW, to);
        if (to) return;
        model_ret++;
    endtask

    task automatic instr_beq(input int fw, input logic zf);
        ctl_t e;
        logic to;
        cycles = 0;
        do_fetch(fw, OP_R, to);
        if (to) return;
        do_decode(OP_BEQ);
        e = idle(); e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01;
        cyc(1'b1, 1'b1, OP_R, zf, e, "branch");
        model_ret++;
    endtask

    task automatic instr_bad(input logic [5:0] op);
        logic to;
        cycles = 0;
        do_fetch(0, op, to);
        do_decode(op);
    endtask

    task automatic err_hold(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'(i % 2), 6'(i * 7), 1'((i / 2) % 2), idle(), "error_hold");
    endtask

    initial begin
        logic to;

        do_reset();
        do_reset();

        instr_r(0);
        check("r_latency", cycles, 4);
        check("r_retired_count", model_ret, 1);
        instr_lw(0, 0);
        check("lw_latency", cycles, 5);
        instr_lw(0, 3);
        check("lw_wait3_latency", cycles, 8);
        instr_sw(0, 0);
        check("sw_latency", cycles, 4);
        instr_beq(0, 1'b1);
        check("beq_taken_latency", cycles, 3);
        instr_beq(0, 1'b0);
        check("beq_nottaken_latency", cycles, 3);
        check("retired_after_six", model_ret, 6);
        instr_sw(2, 1);
        check("sw_waits_latency", cycles, 7);
        instr_r(3);
        check("r_fetch_waits_latency", cycles, 7);

        // Listo arriving on the very last allowed cycle
        instr_lw(TO - 1, 0);
        check("lw_fetch_boundary_latency", cycles, 20);
        check("lw_fetch_boundary_no_error", int'(model_err), 0);
        instr_lw(0, TO - 1);
        check("lw_mem_boundary_latency", cycles, 20);
        instr_sw(0, TO - 1);
        check("sw_mem_boundary_latency", cycles, 19);

        // Push the 4-bit retired counter past its wrap
        for (int k = 0; k < 7; k++) instr_r(0);
        check("retired_wrapped_total", model_ret, 18);

        // Write timeout, then error is absorbing
        instr_sw(0, TO);
        check("sw_timeout_error", int'(model_err), 1);
        err_hold(5);

        // Fetch timeout after 16 waiting cycles
        do_reset();
        instr_r(TO);
        check("fetch_timeout_cycles", cycles, 16);
        err_hold(5);

        // Read timeout
        do_reset();
        instr_lw(1, 20);
        err_hold(3);

        // Reset in the middle of a read request
        do_reset();
        cycles = 0;
        do_fetch(0, OP_SW, to);
        do_decode(OP_LW);
        do_mem_addr(OP_SW);
        cyc(1'b1, 1'b0, OP_SW, 1'b0, '{iord: 1'b1, mrd: 1'b1, default: '0}, "mem_rd_wait");
        do_reset();
        instr_r(0);
        check("r_after_abort_retired", model_ret, 1);

        // Illegal opcodes
        instr_bad(OP_BAD);
        err_hold(20);
        do_reset();
        instr_bad(6'b001000);
        err_hold(3);
        do_reset();
        instr_beq(0, 1'b1);

        @(negedge CLK);
        #1;
        exp_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
